mem_access_arbiter: RTL and testbench
=====================================

Name: mem_access_arbiter

Overview:
- Shares one single-port clocked memory between two requesters: the upstream processor (writes) and the downstream processor (reads).
- Requests are arbitrated round-robin. The block sequences the memory strobes and returns a one-cycle ack per completed transaction.
- Sits between the processor FSMs and the clocked memory. It owns mem_en/mem_wr; no other block drives them.

Parameters:
- ADDR_W, 4, memory address width.
- DATA_W, 8, memory data width.
- RD_LAT, 1, memory read latency in cycles from the mem_en cycle to valid mem_rdata. Legal range is 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- up_req  in  1  upstream write request, held until up_ack.
- up_addr  in  ADDR_W  write address, stable while up_req.
- up_wdata  in  DATA_W  write data, stable while up_req.
- up_ack  out  1  one-cycle pulse: write performed.
- dn_req  in  1  downstream read request, held until dn_ack.
- dn_addr  in  ADDR_W  read address, stable while dn_req.
- dn_rdata  out  DATA_W  registered read data, valid while dn_ack=1.
- dn_ack  out  1  one-cycle pulse: read data valid.
- mem_en  out  1  memory enable.
- mem_wr  out  1  1=write, 0=read; meaningful only with mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous, active-low (rst_n).
- Outputs: all registered, decoded from the state register.
- Reset values:
  - state=IDLE, last_grant=DN.
  - up_ack, dn_ack, mem_en, mem_wr, busy = 0.
  - mem_addr, mem_wdata, dn_rdata = 0.
  - wait counter = 0.
- States: IDLE, WR, RD, WAIT, RACK.
- IDLE:
  - Samples up_req and dn_req at the rising edge.
  - If only one is high, that requester is granted.
  - If both are high, the requester that is not last_grant is granted, and last_grant is updated.
  - Grant UP -> WR. Grant DN -> RD. No request -> stay in IDLE.
- WR (1 cycle):
  - mem_en=1, mem_wr=1, mem_addr=up_addr, mem_wdata=up_wdata, up_ack=1.
  - Next state IDLE.
- RD (1 cycle):
  - mem_en=1, mem_wr=0, mem_addr=dn_addr.
  - Load the wait counter with RD_LAT-1. Next state WAIT.
- WAIT:
  - mem_en=0.
  - When the counter reaches 0, capture mem_rdata into dn_rdata at the clock edge and go to RACK. Otherwise decrement the counter.
- RACK (1 cycle):
  - dn_ack=1; dn_rdata holds the captured value.
  - Next state IDLE.
  - dn_rdata keeps its value after RACK until the next read capture.
- Latency, counted from the edge where the request is sampled in IDLE:
  - up_ack is high in the 1st following cycle.
  - dn_ack is high in cycle RD_LAT+2 (cycle 3 when RD_LAT=1).
- Turnaround: IDLE always separates transactions, so at most one transaction is in flight.
  - Back-to-back requests from the same requester cost one idle cycle each.
- Handshake rules:
  - The requester deasserts req in the cycle after ack. A req still high in IDLE after the ack is a new request.
  - If req drops mid-transaction, the transaction still completes and acks. The bench flags this as a protocol violation; the RTL does not abort.
- Fairness: with both requesters continuously active, grants alternate UP, DN, UP, DN, ... Neither requester waits more than one transaction.
- mem_addr and mem_wdata hold their last values outside WR/RD. Only mem_en qualifies them.
- Reset mid-operation: the state returns to IDLE immediately. No ack is issued for the interrupted transaction, and a half-done read leaves dn_rdata at 0.

Decomposition:
- Package mem_arb_pkg contains:
  - typedef enum arb_state_t {IDLE, WR, RD, WAIT, RACK};
  - typedef enum grant_t {GNT_UP, GNT_DN};
  - localparam for the counter width (3 bits, sized from the maximum RD_LAT of 7).
- Sub-module rr_arbiter2 (combinational):
  - Inputs: two request bits and last_grant.
  - Outputs: grant_valid and grant_t.
  - Kept separate so the bench can test it exhaustively.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles -> all outputs 0, busy=0. Release with no requests -> stays in IDLE.
2. Single write: up_req=1, up_addr=4'h3, up_wdata=8'hA5 -> next cycle shows mem_en=1, mem_wr=1, mem_addr=3, mem_wdata=A5, up_ack=1. busy then falls.
3. Single read after test 2: dn_req=1, dn_addr=3, RD_LAT=1 -> mem_en=1, mem_wr=0 in cycle 1. In cycle 3, dn_ack=1 and dn_rdata=8'hA5.
4. Contention: up_req and dn_req both raised from reset and held (each requester re-raises after its ack) -> grant order UP, DN, UP, DN over 4 transactions. Ack counts equal.
5. RD_LAT=3 build: a read -> dn_ack arrives in cycle 5 with data from the memory model. mem_en is high for exactly 1 cycle.
6. Reset mid-read: assert rst_n=0 in the WAIT state -> state goes to IDLE asynchronously. No dn_ack is produced and dn_rdata=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and sizing for the single-port memory access arbiter.
package mem_arb_pkg;

  localparam int unsigned RD_LAT_MAX = 7;
  localparam int unsigned CNT_W      = $clog2(RD_LAT_MAX + 1);

  typedef enum logic [2:0] {IDLE, WR, RD, WAIT, RACK} arb_state_t;
  typedef enum logic {GNT_UP, GNT_DN} grant_t;

  function automatic grant_t other_grant(input grant_t g);
    return (g == GNT_UP) ? GNT_DN : GNT_UP;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant decode; on contention the side not granted last wins.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic   i_up_req,
  input  logic   i_dn_req,
  input  grant_t i_last_grant,
  output logic   o_grant_valid_c,
  output grant_t o_grant_c
);

  always_comb begin
    o_grant_valid_c = i_up_req | i_dn_req;
    o_grant_c       = GNT_UP;
    if (i_up_req && i_dn_req) begin
      o_grant_c = other_grant(i_last_grant);
    end else if (i_dn_req) begin
      o_grant_c = GNT_DN;
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares one clocked single-port memory between an upstream writer and a downstream reader.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              up_req,
  input  logic [ADDR_W-1:0] up_addr,
  input  logic [DATA_W-1:0] up_wdata,
  output logic              up_ack,
  input  logic              dn_req,
  input  logic [ADDR_W-1:0] dn_addr,
  output logic [DATA_W-1:0] dn_rdata,
  output logic              dn_ack,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(RD_LAT - 1);

  arb_state_t       r_state;
  grant_t           r_last_grant;
  logic [CNT_W-1:0] r_wait_cnt;

  logic   w_grant_valid;
  grant_t w_grant;

  rr_arbiter2 u_rr_arbiter2 (
    .i_up_req        (up_req),
    .i_dn_req        (dn_req),
    .i_last_grant    (r_last_grant),
    .o_grant_valid_c (w_grant_valid),
    .o_grant_c       (w_grant)
  );

  // Outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= GNT_DN;
      r_wait_cnt   <= '0;
      up_ack       <= 1'b0;
      dn_ack       <= 1'b0;
      mem_en       <= 1'b0;
      mem_wr       <= 1'b0;
      busy         <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      dn_rdata     <= '0;
    end else begin
      up_ack <= 1'b0;
      dn_ack <= 1'b0;
      mem_en <= 1'b0;
      mem_wr <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            // Fairness pointer only moves when both sides competed.
            if (up_req && dn_req) begin
              r_last_grant <= w_grant;
            end
            busy   <= 1'b1;
            mem_en <= 1'b1;
            if (w_grant == GNT_UP) begin
              r_state   <= WR;
              mem_wr    <= 1'b1;
              mem_addr  <= up_addr;
              mem_wdata <= up_wdata;
              up_ack    <= 1'b1;
            end else begin
              r_state  <= RD;
              mem_addr <= dn_addr;
            end
          end
        end
        WR: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        RD: begin
          r_wait_cnt <= WAIT_INIT;
          r_state    <= WAIT;
        end
        WAIT: begin
          if (r_wait_cnt == '0) begin
            dn_rdata <= mem_rdata;
            dn_ack   <= 1'b1;
            r_state  <= RACK;
          end else begin
            r_wait_cnt <= r_wait_cnt - CNT_W'(1);
          end
        end
        RACK: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter (RD_LAT=1 and RD_LAT=3) and rr_arbiter2.
module tb_mem_access_arbiter;
  import mem_arb_pkg::*;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  // RD_LAT=1 instance
  logic       up_req1, dn_req1, up_ack1, dn_ack1, mem_en1, mem_wr1, busy1;
  logic [3:0] up_addr1, dn_addr1, mem_addr1;
  logic [7:0] up_wdata1, dn_rdata1, mem_wdata1, mem_rdata1;

  // RD_LAT=3 instance
  logic       up_req3, dn_req3, up_ack3, dn_ack3, mem_en3, mem_wr3, busy3;
  logic [3:0] up_addr3, dn_addr3, mem_addr3;
  logic [7:0] up_wdata3, dn_rdata3, mem_wdata3, mem_rdata3;

  // Standalone arbiter
  logic   a_up, a_dn, a_valid;
  grant_t a_last, a_grant;

  mem_access_arbiter #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .up_req(up_req1), .up_addr(up_addr1), .up_wdata(up_wdata1), .up_ack(up_ack1),
    .dn_req(dn_req1), .dn_addr(dn_addr1), .dn_rdata(dn_rdata1), .dn_ack(dn_ack1),
    .mem_en(mem_en1), .mem_wr(mem_wr1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1)
  );

  mem_access_arbiter #(.ADDR_W(4), .DATA_W(8), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .up_req(up_req3), .up_addr(up_addr3), .up_wdata(up_wdata3), .up_ack(up_ack3),
    .dn_req(dn_req3), .dn_addr(dn_addr3), .dn_rdata(dn_rdata3), .dn_ack(dn_ack3),
    .mem_en(mem_en3), .mem_wr(mem_wr3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3)
  );

  rr_arbiter2 u_arb (
    .i_up_req(a_up), .i_dn_req(a_dn), .i_last_grant(a_last),
    .o_grant_valid_c(a_valid), .o_grant_c(a_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: unwritten locations read back as 8'h40 + address.
  logic [7:0]  mem1 [16];
  logic [15:0] vld1;
  logic [7:0]  rd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vld1 <= '0;
    else if (mem_en1 && mem_wr1) vld1[mem_addr1] <= 1'b1;
  always_ff @(posedge clk) begin
    if (mem_en1 && mem_wr1) mem1[mem_addr1] <= mem_wdata1;
    if (mem_en1 && !mem_wr1) rd1 <= vld1[mem_addr1] ? mem1[mem_addr1] : (8'h40 + {4'h0, mem_addr1});
  end
  assign mem_rdata1 = rd1;

  logic [7:0]  mem3 [16];
  logic [15:0] vld3;
  logic [7:0]  rp3 [3];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vld3 <= '0;
    else if (mem_en3 && mem_wr3) vld3[mem_addr3] <= 1'b1;
  always_ff @(posedge clk) begin
    if (mem_en3 && mem_wr3) mem3[mem_addr3] <= mem_wdata3;
    if (mem_en3 && !mem_wr3) rp3[0] <= vld3[mem_addr3] ? mem3[mem_addr3] : (8'h40 + {4'h0, mem_addr3});
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end
  assign mem_rdata3 = rp3[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int         n, ups, dns, ack_cyc, en_cnt, ack_seen;
    logic       done;
    logic [3:0] grants;
    logic [7:0] exp_v, exp_g, ack_data;
    logic [2:0] idx;

    errors = 0; checks = 0;
    rst_n = 1'b0;
    up_req1 = 0; dn_req1 = 0; up_addr1 = '0; dn_addr1 = '0; up_wdata1 = '0;
    up_req3 = 0; dn_req3 = 0; up_addr3 = '0; dn_addr3 = '0; up_wdata3 = '0;
    a_up = 0; a_dn = 0; a_last = GNT_UP;

    // 1: reset state
    tick(); tick(); tick();
    chk("rst_up_ack", up_ack1, 0);
    chk("rst_dn_ack", dn_ack1, 0);
    chk("rst_mem_en", mem_en1, 0);
    chk("rst_mem_wr", mem_wr1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_mem_addr", mem_addr1, 0);
    chk("rst_mem_wdata", mem_wdata1, 0);
    chk("rst_dn_rdata", dn_rdata1, 0);
    chk("rst_up_ack3", up_ack3, 0);
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_busy", busy1, 0);
    chk("idle_mem_en", mem_en1, 0);

    // rr_arbiter2 exhaustive; index = {up, dn, last}, grant bit 1 = DN
    exp_v = 8'b1111_1100;
    exp_g = 8'b0100_1100;
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      a_up = idx[2]; a_dn = idx[1]; a_last = grant_t'(idx[0]);
      #1;
      chk($sformatf("arb_valid_%0d", i), a_valid, exp_v[idx]);
      if (exp_v[idx]) chk($sformatf("arb_grant_%0d", i), a_grant, exp_g[idx]);
    end

    // 2: single write, then a held request becomes a second write after one idle cycle
    up_req1 = 1; up_addr1 = 4'h3; up_wdata1 = 8'hA5;
    tick();
    chk("wr_mem_en", mem_en1, 1);
    chk("wr_mem_wr", mem_wr1, 1);
    chk("wr_mem_addr", mem_addr1, 4'h3);
    chk("wr_mem_wdata", mem_wdata1, 8'hA5);
    chk("wr_up_ack", up_ack1, 1);
    chk("wr_busy", busy1, 1);
    up_addr1 = 4'h7; up_wdata1 = 8'h3C;
    tick();
    chk("wr_gap_ack", up_ack1, 0);
    chk("wr_gap_busy", busy1, 0);
    chk("wr_gap_en", mem_en1, 0);
    chk("wr_hold_addr", mem_addr1, 4'h3);
    tick();
    chk("wr2_ack", up_ack1, 1);
    chk("wr2_addr", mem_addr1, 4'h7);
    chk("wr2_wdata", mem_wdata1, 8'h3C);
    up_req1 = 0;
    tick();
    chk("wr2_busy_fall", busy1, 0);

    // 3: read back address 3, RD_LAT=1
    dn_req1 = 1; dn_addr1 = 4'h3;
    tick();
    chk("rd_mem_en", mem_en1, 1);
    chk("rd_mem_wr", mem_wr1, 0);
    chk("rd_mem_addr", mem_addr1, 4'h3);
    tick();
    chk("rd_c2_ack", dn_ack1, 0);
    chk("rd_c2_en", mem_en1, 0);
    tick();
    chk("rd_c3_ack", dn_ack1, 1);
    chk("rd_c3_data", dn_rdata1, 8'hA5);
    dn_req1 = 0;
    tick();
    chk("rd_ack_pulse", dn_ack1, 0);
    chk("rd_data_hold", dn_rdata1, 8'hA5);
    chk("rd_busy_fall", busy1, 0);

    // 4: contention from reset alternates UP, DN, UP, DN
    rst_n = 0; tick(); tick(); rst_n = 1;
    n = 0; ups = 0; dns = 0; done = 0; grants = '0;
    up_req1 = 1; dn_req1 = 1; up_addr1 = 4'h1; up_wdata1 = 8'h11; dn_addr1 = 4'h2;
    for (int c = 0; c < 40 && !done; c++) begin
      tick();
      if (mem_en1) begin
        if (n < 4) grants[n] = mem_wr1;
        n++;
      end
      if (up_ack1) ups++;
      if (dn_ack1) dns++;
      if (n >= 4) up_req1 = 0;
      if (n >= 4 && dn_ack1) begin
        dn_req1 = 0;
        done = 1;
      end
    end
    chk("rr_done", done, 1);
    chk("rr_count", n, 4);
    chk("rr_order", grants, 4'b0101);
    chk("rr_up_acks", ups, 2);
    chk("rr_dn_acks", dns, 2);

    // 5: RD_LAT=3 read of unwritten address 5
    dn_req3 = 1; dn_addr3 = 4'h5;
    en_cnt = 0; ack_cyc = 0; ack_data = '0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (mem_en3) en_cnt++;
      if (dn_ack3 && ack_cyc == 0) begin
        ack_cyc = c;
        ack_data = dn_rdata3;
      end
      if (dn_ack3) dn_req3 = 0;
    end
    chk("lat3_ack_cycle", ack_cyc, 5);
    chk("lat3_data", ack_data, 8'h45);
    chk("lat3_en_cycles", en_cnt, 1);

    // 6: reset while waiting on read data
    dn_req3 = 1; dn_addr3 = 4'h9;
    tick(); tick();
    chk("mid_busy", busy3, 1);
    chk("mid_state", 32'(u_dut3.r_state), 32'(WAIT));
    #2 rst_n = 0;
    #1;
    chk("async_state", 32'(u_dut3.r_state), 32'(IDLE));
    chk("async_busy", busy3, 0);
    chk("async_rdata", dn_rdata3, 0);
    dn_req3 = 0;
    tick(); tick();
    rst_n = 1;
    ack_seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (dn_ack3) ack_seen++;
    end
    chk("abort_no_ack", ack_seen, 0);
    chk("abort_rdata", dn_rdata3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
